// File: rtl/spm_seq_ctrl.sv
// Sequencer for the spm serial-parallel multiplier: holds the multiplicand on x_par,
// streams the sign/zero-extended multiplier LSB-first on y_ser and gathers the product from p_ser.
module spm_seq_ctrl #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1,
    parameter int P_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mc,
    input  logic [WIDTH-1:0]   mp,
    output logic               ready,
    output logic [WIDTH-1:0]   x_par,
    output logic               spm_clr,
    output logic               y_ser,
    input  logic               p_ser,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int PW        = 2 * WIDTH;
    localparam int SHIFT_CYC = PW + P_LAT;
    localparam int CNT_W     = $clog2(SHIFT_CYC + 1);
    localparam int IDX_W     = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ACC  = CNT_W'(P_LAT);
    localparam logic [CNT_W-1:0] CNT_EXT  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(PW);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] mp_sh;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_nxt;
    logic             accept;

    // Serial multiplier bit k: operand bits, then the extension word, then zeros while the pipe drains.
    function automatic logic y_bit(input logic [WIDTH-1:0] m, input logic [CNT_W-1:0] k);
        logic b;
        b = 1'b0;
        if (k < CNT_EXT) begin
            b = m[k[IDX_W-1:0]];
        end else if (k < CNT_END) begin
            b = (SIGNED != 0) ? m[WIDTH-1] : 1'b0;
        end
        return b;
    endfunction

    assign cnt_nxt = cnt + CNT_W'(1);
    assign acc_nxt = {p_ser, acc[PW-1:1]};
    assign accept  = (state == ST_IDLE) && start;

    // Operand and accumulator storage carries no reset; every bit is rewritten each job.
    always_ff @(posedge clk) begin
        if (accept) begin
            mp_sh <= mp;
        end
        if ((state == ST_SHIFT) && (cnt >= CNT_ACC)) begin
            acc <= acc_nxt;
        end
    end

    // Outputs are registered alongside the state so they change exactly on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            spm_clr <= 1'b1;
            y_ser   <= 1'b0;
            x_par   <= '0;
            prod    <= '0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    y_ser <= 1'b0;
                    if (start) begin
                        state   <= ST_CLEAR;
                        ready   <= 1'b0;
                        spm_clr <= 1'b1;
                        x_par   <= mc;
                        cnt     <= '0;
                    end else begin
                        ready   <= 1'b1;
                        spm_clr <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    state   <= ST_SHIFT;
                    spm_clr <= 1'b0;
                    cnt     <= '0;
                    y_ser   <= y_bit(mp_sh, '0);
                end
                ST_SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        // Capture including the final p_ser bit so prod is valid for the whole DONE cycle.
                        state <= ST_DONE;
                        y_ser <= 1'b0;
                        done  <= 1'b1;
                        prod  <= acc_nxt;
                    end else begin
                        cnt   <= cnt_nxt;
                        y_ser <= y_bit(mp_sh, cnt_nxt);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready   <= 1'b1;
                    spm_clr <= 1'b0;
                    y_ser   <= 1'b0;
                end
            endcase
        end
    end

endmodule
